// File: rtl/jt6295_pkg.sv
`timescale 1ns/1ps
// jt6295_pkg
// Shared definitions for the JT6295 serial channel sequencer:
//   - slot_w()     : slot index width for a given channel count
//   - csr_w()      : width of one per-channel state word in the CSR ring
//   - OFF_* / off_*: bit offsets of the fields inside a state word
//   - NIB_HI/NIB_LO: value of cnt[0] selecting the high / low ROM nibble
// Build option: JT6295_LOOP_EN adds an AW-bit loop-start field to each
// state word.
package jt6295_pkg;

   localparam logic NIB_HI = 1'b0;
   localparam logic NIB_LO = 1'b1;

   // State word layout, LSB first:
   //   busy | loop | att[ATTW] | stop[AW] | cnt[AW+1] | lstart[AW] (loop build)
   localparam int OFF_BUSY = 0;
   localparam int OFF_LOOP = 1;
   localparam int OFF_ATT  = 2;

   function automatic int slot_w(input int ch);
      return (ch <= 2) ? 1 : $clog2(ch);
   endfunction

   function automatic int off_stop(input int attw);
      return OFF_ATT + attw;
   endfunction

   function automatic int off_cnt(input int aw, input int attw);
      return OFF_ATT + attw + aw;
   endfunction

   function automatic int off_lstart(input int aw, input int attw);
      return OFF_ATT + attw + aw + (aw + 1);
   endfunction

   function automatic int csr_w(input int aw, input int attw);
`ifdef JT6295_LOOP_EN
      return aw + (aw + 1) + attw + 2 + aw;
`else
      return aw + (aw + 1) + attw + 2;
`endif
   endfunction

endpackage

// File: rtl/jt6295_csr_ring.sv
`timescale 1ns/1ps
// jt6295_csr_ring
// CH-stage circular shift register holding one state word per channel.
// Stage 0 always holds the channel of the current slot; on every cen4 the
// updated word for that channel enters at the tail while the ring advances,
// so a single update datapath serves every channel.
// Ports:
//   clk_i   : system clock
//   rst_n_i : synchronous active-low reset, clears every stage
//   cen4_i  : shift enable (one slot per pulse)
//   din_i   : updated state word of the current slot
//   dout_o  : state word of the current slot
module jt6295_csr_ring #(
   parameter int CH = 4,
   parameter int W  = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         cen4_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o
);

   logic [W-1:0] ring_q [CH];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < CH; i++) ring_q[i] <= '0;
      end else if (cen4_i) begin
         for (int i = 0; i < CH - 1; i++) ring_q[i] <= ring_q[i+1];
         ring_q[CH-1] <= din_i;
      end
   end

   assign dout_o = ring_q[0];

endmodule

// File: rtl/jt6295_serial_mc.sv
`timescale 1ns/1ps
// jt6295_serial_mc
// Time-multiplexed ADPCM channel sequencer. One channel slot is serviced per
// cen4; the slot's ROM nibble address is issued and a serial stream
// (pipe_en/pipe_att/pipe_data/pipe_slot) feeds the shared decoder two cen4
// later. Commands (start/stop bits plus one shared parameter set) are
// captured at the frame boundary and applied on each channel's own slot.
// Ports:
//   clk, rst_n (sync, active-low), cen4 (slot advance enable)
//   start_addr/stop_addr/att/loop : parameters for channels started this frame
//   start/stop  : per-channel command bits       busy : per-channel playing
//   zero        : current slot is CH-1           slot : current slot
//   rom_addr    : ROM byte address of this slot  rom_data : ROM byte, one cen4 later
//   pipe_en/pipe_att/pipe_data/pipe_slot : serial sample stream
// Build option: JT6295_LOOP_EN enables loop playback (loop input and
// per-channel loop-start storage). Without it, reaching stop ends playback.
module jt6295_serial_mc
   import jt6295_pkg::*;
#(
   parameter  int CH   = 4,
   parameter  int AW   = 18,
   parameter  int ATTW = 4,
   localparam int SW   = slot_w(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen4,
   input  logic [AW-1:0]   start_addr,
   input  logic [AW-1:0]   stop_addr,
   input  logic [ATTW-1:0] att,
   input  logic            loop,
   input  logic [CH-1:0]   start,
   input  logic [CH-1:0]   stop,
   output logic [CH-1:0]   busy,
   output logic            zero,
   output logic [SW-1:0]   slot,
   output logic [AW-1:0]   rom_addr,
   input  logic [7:0]      rom_data,
   output logic            pipe_en,
   output logic [ATTW-1:0] pipe_att,
   output logic [3:0]      pipe_data,
   output logic [SW-1:0]   pipe_slot
);

   localparam int CSRW   = csr_w(AW, ATTW);
   localparam int O_STOP = off_stop(ATTW);
   localparam int O_CNT  = off_cnt(AW, ATTW);
   localparam logic [SW-1:0] LAST_SLOT = SW'(CH - 1);

   logic [SW-1:0]   slot_q, slot_d;
   logic            frame_end;
   logic [CH-1:0]   start_lat_q, stop_lat_q, busy_q;
   logic [AW-1:0]   sa_lat_q, ea_lat_q;
   logic [ATTW-1:0] att_lat_q;

   logic [CSRW-1:0] csr_q, csr_d;
   logic [AW:0]     cnt_h, cnt_d;
   logic [AW-1:0]   stop_h, stop_d;
   logic [ATTW-1:0] att_h, att_d;
   logic            busy_h, busy_d;
   logic            start_hit, stop_hit, at_end;

   logic            s1_sel_q, s1_en_q;
   logic [ATTW-1:0] s1_att_q;
   logic [SW-1:0]   s1_slot_q;
   logic            pipe_en_q;
   logic [ATTW-1:0] pipe_att_q;
   logic [3:0]      pipe_data_q;
   logic [SW-1:0]   pipe_slot_q;

`ifdef JT6295_LOOP_EN
   localparam int O_LSTART = off_lstart(AW, ATTW);
   logic            loop_lat_q;
   logic            loop_h, loop_d;
   logic [AW-1:0]   lstart_h, lstart_d;
   assign loop_h   = csr_q[OFF_LOOP];
   assign lstart_h = csr_q[O_LSTART +: AW];
`else
   logic            loop_unused;
   assign loop_unused = loop ^ csr_q[OFF_LOOP];
`endif

   jt6295_csr_ring #(.CH(CH), .W(CSRW)) u_ring (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .cen4_i  (cen4),
      .din_i   (csr_d),
      .dout_o  (csr_q)
   );

   assign frame_end = (slot_q == LAST_SLOT);
   assign slot_d    = frame_end ? '0 : slot_q + SW'(1);

   assign cnt_h  = csr_q[O_CNT +: AW+1];
   assign stop_h = csr_q[O_STOP +: AW];
   assign att_h  = csr_q[OFF_ATT +: ATTW];
   assign busy_h = csr_q[OFF_BUSY];

   assign start_hit = start_lat_q[slot_q];
   assign stop_hit  = stop_lat_q[slot_q];
   // cnt points at the nibble issued last frame; the channel is finished
   // once that nibble was the low nibble of the stop byte or lay beyond it.
   assign at_end    = (cnt_h >= {stop_h, NIB_LO});

   // Single update datapath for the channel sitting at the ring head.
   always_comb begin
      cnt_d  = cnt_h;
      stop_d = stop_h;
      att_d  = att_h;
      busy_d = busy_h;
`ifdef JT6295_LOOP_EN
      loop_d   = loop_h;
      lstart_d = lstart_h;
`endif
      if (start_hit) begin
         cnt_d  = {sa_lat_q, NIB_HI};
         stop_d = ea_lat_q;
         att_d  = att_lat_q;
         busy_d = 1'b1;
`ifdef JT6295_LOOP_EN
         loop_d   = loop_lat_q;
         lstart_d = sa_lat_q;
`endif
      end else if (stop_hit) begin
         busy_d = 1'b0;
      end else if (busy_h && at_end) begin
`ifdef JT6295_LOOP_EN
         if (loop_h) cnt_d = {lstart_h, NIB_HI};
         else        busy_d = 1'b0;
`else
         busy_d = 1'b0;
`endif
      end else if (busy_h) begin
         cnt_d = cnt_h + {{AW{1'b0}}, 1'b1};
      end
   end

   always_comb begin
      csr_d = '0;
      csr_d[O_CNT +: AW+1]  = cnt_d;
      csr_d[O_STOP +: AW]   = stop_d;
      csr_d[OFF_ATT +: ATTW] = att_d;
      csr_d[OFF_BUSY]       = busy_d;
`ifdef JT6295_LOOP_EN
      csr_d[OFF_LOOP]       = loop_d;
      csr_d[O_LSTART +: AW] = lstart_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q      <= '0;
         start_lat_q <= '0;
         stop_lat_q  <= '0;
         sa_lat_q    <= '0;
         ea_lat_q    <= '0;
         att_lat_q   <= '0;
`ifdef JT6295_LOOP_EN
         loop_lat_q  <= 1'b0;
`endif
         busy_q      <= '0;
         s1_sel_q    <= 1'b0;
         s1_en_q     <= 1'b0;
         s1_att_q    <= '0;
         s1_slot_q   <= '0;
         pipe_en_q   <= 1'b0;
         pipe_att_q  <= '0;
         pipe_data_q <= '0;
         pipe_slot_q <= '0;
      end else if (cen4) begin
         slot_q         <= slot_d;
         busy_q[slot_q] <= busy_d;
         // Slot CH-1's old bits are consumed on this same edge, so the
         // capture can overwrite the whole latch set.
         if (frame_end) begin
            start_lat_q <= start;
            stop_lat_q  <= stop;
            sa_lat_q    <= start_addr;
            ea_lat_q    <= stop_addr;
            att_lat_q   <= att;
`ifdef JT6295_LOOP_EN
            loop_lat_q  <= loop;
`endif
         end else begin
            start_lat_q[slot_q] <= 1'b0;
            stop_lat_q[slot_q]  <= 1'b0;
         end
         // Stage 1: what the ROM byte arriving next cen4 is for.
         s1_sel_q    <= cnt_d[0];
         s1_en_q     <= busy_d;
         s1_att_q    <= att_d;
         s1_slot_q   <= slot_q;
         // Stage 2: nibble pick from the ROM byte.
         pipe_en_q   <= s1_en_q;
         pipe_att_q  <= s1_att_q;
         pipe_slot_q <= s1_slot_q;
         pipe_data_q <= (s1_sel_q == NIB_LO) ? rom_data[3:0] : rom_data[7:4];
      end
   end

   assign busy      = busy_q;
   assign zero      = frame_end;
   assign slot      = slot_q;
   assign rom_addr  = cnt_d[AW:1];
   assign pipe_en   = pipe_en_q;
   assign pipe_att  = pipe_att_q;
   assign pipe_data = pipe_data_q;
   assign pipe_slot = pipe_slot_q;

endmodule

// File: tb/tb_jt6295_serial_mc.sv
`timescale 1ns/1ps
module tb_jt6295_serial_mc;

   localparam int AW   = 18;
   localparam int ATTW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;
   logic cen4  = 1'b0;

   // ---------------- DUT A: CH=4, AW=18 ----------------
   logic [AW-1:0]   start_addr = '0, stop_addr = '0, rom_addr;
   logic [ATTW-1:0] att = '0, pipe_att;
   logic            loop = 1'b0, zero, pipe_en;
   logic [3:0]      start = '0, stop = '0, busy, pipe_data;
   logic [1:0]      slot, pipe_slot;
   logic [7:0]      rom_data = '0;

   jt6295_serial_mc #(.CH(4), .AW(AW), .ATTW(ATTW)) u_dut (
      .clk(clk), .rst_n(rst_n), .cen4(cen4),
      .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .loop(loop),
      .start(start), .stop(stop), .busy(busy), .zero(zero), .slot(slot),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .pipe_en(pipe_en), .pipe_att(pipe_att), .pipe_data(pipe_data), .pipe_slot(pipe_slot)
   );

   // ---------------- DUT B: CH=8, AW=20 ----------------
   logic [19:0]     start_addr8 = '0, stop_addr8 = '0, rom_addr8;
   logic [ATTW-1:0] att8 = '0, pipe_att8;
   logic            loop8 = 1'b0, zero8, pipe_en8;
   logic [7:0]      start8 = '0, stop8 = '0, busy8, rom_data8 = '0;
   logic [2:0]      slot8, pipe_slot8;
   logic [3:0]      pipe_data8;

   jt6295_serial_mc #(.CH(8), .AW(20), .ATTW(ATTW)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .cen4(cen4),
      .start_addr(start_addr8), .stop_addr(stop_addr8), .att(att8), .loop(loop8),
      .start(start8), .stop(stop8), .busy(busy8), .zero(zero8), .slot(slot8),
      .rom_addr(rom_addr8), .rom_data(rom_data8),
      .pipe_en(pipe_en8), .pipe_att(pipe_att8), .pipe_data(pipe_data8), .pipe_slot(pipe_slot8)
   );

   // ROM model: byte = low address byte + 0x5A, registered on cen4
   function automatic logic [7:0] rom_byte(input logic [19:0] a);
      return a[7:0] + 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (cen4) begin
         rom_data  <= rom_byte(20'(rom_addr));
         rom_data8 <= rom_byte(rom_addr8);
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [3:0]    exp_q[$];
   logic [AW-1:0] exp_addr_a [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      cen4 = 1'b1;
      @(posedge clk); #1;
      cen4 = 1'b0;
      @(posedge clk); #1;
   endtask

   // cen4 held high during reset: reset must still win
   task automatic do_reset();
      start = '0; stop = '0; start8 = '0; stop8 = '0;
      rst_n = 1'b0; cen4 = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; cen4 = 1'b0;
   endtask

   // Drive a command until the frame-boundary capture; returns at slot 0.
   task automatic send(input logic [3:0] st, input logic [3:0] sp,
                       input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                       input logic [ATTW-1:0] a, input logic lp);
      int guard;
      guard = 0;
      start = st; stop = sp; start_addr = sa; stop_addr = ea; att = a; loop = lp;
      while (zero !== 1'b1 && guard < 8) begin
         tick();
         guard++;
      end
      check("send_zero_seen", zero, 1);
      tick();
      start = '0; stop = '0;
   endtask

   // Channel 0 playback: rom_addr on its slot, busy after service, pipe 2 cen4 later.
   task automatic play_frames(input int n, input logic [ATTW-1:0] a);
      for (int f = 0; f < n; f++) begin
         check("slot0_rom_addr", rom_addr, exp_addr_a[f]);
         tick();
         check("busy0_playing", busy[0], 1);
         tick();
         check("pipe_en", pipe_en, 1);
         check("pipe_slot", pipe_slot, 0);
         check("pipe_att", pipe_att, a);
         check("pipe_data", pipe_data, (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx);
         tick();
         tick();
      end
   endtask

   // ---------------- tests ----------------
   initial begin
      do_reset();

      // Reset mid-play
      send(4'b0011, 4'b0000, 18'h00100, 18'h001FF, 4'd3, 1'b0);
      tick(); tick();
      check("midplay_busy", busy, 4'b0011);
      check("midplay_pipe_en", pipe_en, 1);
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_pipe_en", pipe_en, 0);
      check("rst_slot", slot, 0);
      check("rst_zero", zero, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_pipe_data", pipe_data, 0);
      check("rst_pipe_att", pipe_att, 0);
      check("rst_pipe_slot", pipe_slot, 0);

      // One-shot: 0x100..0x101, nibbles 5,A,5,B
      do_reset();
      send(4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'd5, 1'b0);
      exp_addr_a[0] = 18'h00100; exp_addr_a[1] = 18'h00100;
      exp_addr_a[2] = 18'h00101; exp_addr_a[3] = 18'h00101;
      exp_q = {};
      exp_q.push_back(4'h5); exp_q.push_back(4'hA);
      exp_q.push_back(4'h5); exp_q.push_back(4'hB);
      play_frames(4, 4'd5);
      tick();
      check("oneshot_busy_end", busy[0], 0);
      tick();
      check("oneshot_pipe_en_end", pipe_en, 0);

      // Loop request
      do_reset();
      send(4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'd5, 1'b1);
      exp_q = {};
`ifdef JT6295_LOOP_EN
      exp_addr_a[4] = 18'h00100; exp_addr_a[5] = 18'h00100;
      exp_q.push_back(4'h5); exp_q.push_back(4'hA);
      exp_q.push_back(4'h5); exp_q.push_back(4'hB);
      exp_q.push_back(4'h5); exp_q.push_back(4'hA);
      play_frames(6, 4'd5);
      send(4'b0000, 4'b0001, 18'h00100, 18'h00101, 4'd5, 1'b1);
      tick();
      check("loop_stop_busy", busy[0], 0);
`else
      exp_q.push_back(4'h5); exp_q.push_back(4'hA);
      exp_q.push_back(4'h5); exp_q.push_back(4'hB);
      play_frames(4, 4'd5);
      tick();
      check("noloop_busy_end", busy[0], 0);
`endif

      // Simultaneous start and stop on channel 2: start wins
      do_reset();
      send(4'b0100, 4'b0100, 18'h00020, 18'h00030, 4'd2, 1'b0);
      tick(); tick();
      check("ch2_rom_addr", rom_addr, 18'h00020);
      tick();
      check("ch2_start_wins", busy, 4'b0100);
      send(4'b0000, 4'b0100, 18'h00020, 18'h00030, 4'd2, 1'b0);
      tick(); tick(); tick();
      check("ch2_stopped", busy, 4'b0000);

      // cen4 low for 20 clocks mid-play
      do_reset();
      send(4'b0001, 4'b0000, 18'h00040, 18'h000FF, 4'd7, 1'b0);
      tick(); tick(); tick(); tick();
      cen4 = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("frz_slot", slot, 0);
      check("frz_zero", zero, 0);
      check("frz_busy", busy, 4'b0001);
      check("frz_rom_addr", rom_addr, 18'h00040);
      check("frz_pipe_slot", pipe_slot, 2);
      check("frz_pipe_en", pipe_en, 0);
      tick();
      check("frz_resume_slot", slot, 1);
      tick();
      check("frz_resume_pipe_en", pipe_en, 1);
      check("frz_resume_pipe_data", pipe_data, 4'hA);
      check("frz_resume_pipe_slot", pipe_slot, 0);
      check("frz_resume_pipe_att", pipe_att, 7);

      // CH=8, AW=20: stop below start plays one nibble; slot wrap 7->0
      do_reset();
      start8 = 8'h01; stop8 = '0;
      start_addr8 = 20'h00010; stop_addr8 = 20'h00000; att8 = 4'd9; loop8 = 1'b0;
      repeat (7) tick();
      check("ch8_slot7", slot8, 7);
      check("ch8_zero_on_7", zero8, 1);
      tick();
      start8 = '0;
      check("ch8_wrap_slot", slot8, 0);
      check("ch8_zero_after_wrap", zero8, 0);
      check("ch8_rom_addr", rom_addr8, 20'h00010);
      tick();
      check("ch8_busy", busy8, 8'h01);
      tick();
      check("ch8_pipe_en", pipe_en8, 1);
      check("ch8_pipe_data", pipe_data8, 4'h6);
      check("ch8_pipe_slot", pipe_slot8, 0);
      check("ch8_pipe_att", pipe_att8, 9);
      repeat (6) tick();
      tick();
      check("ch8_busy_end", busy8, 8'h00);
      tick();
      check("ch8_pipe_en_end", pipe_en8, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
